// File: rtl/hist_eq_mapper_pkg.sv
// rtl/hist_eq_mapper_pkg.sv - shared geometry, CDF scaling constants and FSM encoding
package hist_eq_mapper_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int WIDTH      = 110;
  localparam int HEIGHT     = 145;
  localparam int CNT_WIDTH  = 14;
  localparam int SHIFT      = 20;
  localparam int COORD_W    = 11;

  localparam int NBINS   = 2 ** DATA_WIDTH;
  localparam int LUT_MAX = NBINS - 1;

  // SCALE = ceil(LUT_MAX * 2^SHIFT / pixels-per-frame), 16765 for the default geometry
  localparam longint NPIX    = longint'(WIDTH) * longint'(HEIGHT);
  localparam longint SCALE_L = (longint'(LUT_MAX) * (longint'(1) << SHIFT) + NPIX - 1) / NPIX;
  localparam int     SCALE   = int'(SCALE_L);
  localparam int     SCALE_W = $clog2(SCALE + 1);
  localparam int     PROD_W  = CNT_WIDTH + SCALE_W;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    BUILD = 2'd1,
    SWAP  = 2'd2
  } state_t;

endpackage

// File: rtl/hist_eq_lut.sv
// rtl/hist_eq_lut.sv - double-banked remap LUT, write inactive bank, read active bank
module hist_eq_lut
  import hist_eq_mapper_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  toggle,
  input  logic [DATA_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic                  sel;
  logic [DATA_WIDTH-1:0] bank0 [NBINS];
  logic [DATA_WIDTH-1:0] bank1 [NBINS];

  // Both banks start as identity so the first frame after reset passes unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 1'b0;
      for (int v = 0; v < NBINS; v++) begin
        bank0[v] <= DATA_WIDTH'(v);
        bank1[v] <= DATA_WIDTH'(v);
      end
    end else begin
      if (we) begin
        if (sel) bank0[waddr] <= wdata;
        else     bank1[waddr] <= wdata;
      end
      if (toggle) sel <= ~sel;
    end
  end

  assign rdata = sel ? bank1[raddr] : bank0[raddr];

endmodule

// File: rtl/hist_eq_mapper.sv
// rtl/hist_eq_mapper.sv - per-frame luminance histogram, CDF LUT build and pixel remap
module hist_eq_mapper
  import hist_eq_mapper_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    iX,
  input  logic [COORD_W-1:0]    iY,
  input  logic                  iDVAL,
  input  logic [DATA_WIDTH-1:0] iDATA,
  output logic [COORD_W-1:0]    oX,
  output logic [COORD_W-1:0]    oY,
  output logic                  oDVAL,
  output logic [DATA_WIDTH-1:0] oDATA,
  output logic                  oBUSY
);

  localparam int SCALED_W = PROD_W - SHIFT;

  state_t                 state, state_nx;
  logic [CNT_WIDTH-1:0]   hist [NBINS];
  logic [CNT_WIDTH-1:0]   cum;
  logic [DATA_WIDTH-1:0]  k;
  logic                   in_range, eof;
  logic [CNT_WIDTH:0]     cum_sum;
  logic [CNT_WIDTH-1:0]   cum_nx;
  logic [PROD_W-1:0]      prod;
  logic [SCALED_W-1:0]    scaled;
  logic [DATA_WIDTH-1:0]  lut_wdata, lut_rdata;
  logic                   lut_we, lut_toggle;

  assign in_range = iDVAL && (iX < COORD_W'(WIDTH)) && (iY < COORD_W'(HEIGHT));
  assign eof      = in_range && (iX == COORD_W'(WIDTH - 1)) && (iY == COORD_W'(HEIGHT - 1));

  // Running CDF saturates rather than wraps in case a frame repeats coordinates
  assign cum_sum   = {1'b0, cum} + {1'b0, hist[k]};
  assign cum_nx    = cum_sum[CNT_WIDTH] ? '1 : cum_sum[CNT_WIDTH-1:0];
  assign prod      = PROD_W'(cum_nx) * PROD_W'(SCALE);
  assign scaled    = prod[PROD_W-1:SHIFT];
  assign lut_wdata = (scaled > SCALED_W'(LUT_MAX)) ? '1 : scaled[DATA_WIDTH-1:0];

  // Next-state and bank control: one bin per BUILD cycle, one SWAP cycle to flip banks
  always_comb begin
    state_nx   = state;
    lut_we     = 1'b0;
    lut_toggle = 1'b0;
    case (state)
      ACCUM: if (eof) state_nx = BUILD;
      BUILD: begin
        lut_we = 1'b1;
        if (k == DATA_WIDTH'(NBINS - 1)) state_nx = SWAP;
      end
      SWAP: begin
        lut_toggle = 1'b1;
        state_nx   = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  // State register and registered busy flag covering BUILD and SWAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      oBUSY <= 1'b0;
    end else begin
      state <= state_nx;
      oBUSY <= (state_nx != ACCUM);
    end
  end

  // Bin index and cumulative sum walk during BUILD, cleared on SWAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= '0;
      cum <= '0;
    end else if (state == BUILD) begin
      k   <= k + 1'b1;
      cum <= cum_nx;
    end else if (state == SWAP) begin
      k   <= '0;
      cum <= '0;
    end
  end

  // Histogram counts valid in-range pixels in ACCUM, each bin is emptied as BUILD reads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBINS; i++) hist[i] <= '0;
    end else if (state == BUILD) begin
      hist[k] <= '0;
    end else if (state == ACCUM && in_range && hist[iDATA] != '1) begin
      hist[iDATA] <= hist[iDATA] + 1'b1;
    end
  end

  hist_eq_lut u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (lut_we),
    .waddr  (k),
    .wdata  (lut_wdata),
    .toggle (lut_toggle),
    .raddr  (iDATA),
    .rdata  (lut_rdata)
  );

  // One-cycle output pipeline, remapped data holds while iDVAL is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oX    <= '0;
      oY    <= '0;
      oDVAL <= 1'b0;
      oDATA <= '0;
    end else begin
      oX    <= iX;
      oY    <= iY;
      oDVAL <= iDVAL;
      if (iDVAL) oDATA <= lut_rdata;
    end
  end

endmodule
